// File: rtl/phase_unwrapper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phase_unwrapper_pkg
//  Description : Shared defaults, counter width and accumulator saturation
//                limit helpers for the phase unwrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package phase_unwrapper_pkg;

    localparam int PU_PHASE_WIDTH_DEFAULT      = 16;
    localparam int PU_AXIS_TDATA_WIDTH_DEFAULT = 32;
    localparam int WRAP_COUNT_WIDTH            = 16;

    // Largest two's complement value representable in 'width' bits (width <= 64).
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value representable in 'width' bits.
    function automatic logic [63:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage : phase_unwrapper_pkg
`default_nettype wire

// File: rtl/pu_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : pu_accumulator
//  Description : Second pipeline stage of the phase unwrapper. Holds the
//                unwrapped phase accumulator, reloads it on the first sample
//                after reset/clear and adds the shortest-path delta otherwise.
//                With PHASE_UNWRAPPER_SAT_EN defined the add clamps to the
//                signed rails; otherwise it wraps modulo 2^AXIS_TDATA_WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module pu_accumulator
    import phase_unwrapper_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = PU_AXIS_TDATA_WIDTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_valid,
    input  logic                        i_first,
    input  logic [AXIS_TDATA_WIDTH-1:0] i_delta,
    output logic [AXIS_TDATA_WIDTH-1:0] o_acc,
    output logic                        o_valid
);

    logic [AXIS_TDATA_WIDTH-1:0] r_acc;
    logic                        r_valid;
    logic [AXIS_TDATA_WIDTH-1:0] w_sum;

`ifdef PHASE_UNWRAPPER_SAT_EN
    localparam logic [AXIS_TDATA_WIDTH-1:0] c_acc_max = AXIS_TDATA_WIDTH'(sat_max(AXIS_TDATA_WIDTH));
    localparam logic [AXIS_TDATA_WIDTH-1:0] c_acc_min = AXIS_TDATA_WIDTH'(sat_min(AXIS_TDATA_WIDTH));

    logic [AXIS_TDATA_WIDTH:0] w_sum_ext;
    assign w_sum_ext = {r_acc[AXIS_TDATA_WIDTH-1], r_acc}
                     + {i_delta[AXIS_TDATA_WIDTH-1], i_delta};

    // Signed overflow shows as disagreeing top two bits; clamp to the rail on the side of the true sign.
    always_comb begin
        w_sum = w_sum_ext[AXIS_TDATA_WIDTH-1:0];
        if (w_sum_ext[AXIS_TDATA_WIDTH] != w_sum_ext[AXIS_TDATA_WIDTH-1]) begin
            w_sum = w_sum_ext[AXIS_TDATA_WIDTH] ? c_acc_min : c_acc_max;
        end
    end
`else
    assign w_sum = r_acc + i_delta;
`endif

    // Accumulator and output valid: clear beats new data, first sample reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_acc <= i_first ? i_delta : w_sum;
            end
        end
    end

    assign o_acc   = r_acc;
    assign o_valid = r_valid;

endmodule : pu_accumulator
`default_nettype wire

// File: rtl/phase_unwrapper.sv
`default_nettype none
// ============================================================================
//  Module      : phase_unwrapper
//  Description : Turns the wrapped arctan phase stream into a continuous
//                signed displacement. Stage 1 forms the shortest-path delta
//                against the last accepted sample and flags wrap events;
//                stage 2 (pu_accumulator) integrates it. Wrap events are
//                counted with saturation. Optional macro
//                PHASE_UNWRAPPER_SAT_EN makes the accumulator saturate.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_unwrapper
    import phase_unwrapper_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = PU_AXIS_TDATA_WIDTH_DEFAULT,
    parameter int PHASE_WIDTH      = PU_PHASE_WIDTH_DEFAULT
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic                        PU_clear,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    output logic [WRAP_COUNT_WIDTH-1:0] PU_wrap_count
);

    localparam logic [WRAP_COUNT_WIDTH-1:0] c_count_one = WRAP_COUNT_WIDTH'(1);

    logic [PHASE_WIDTH-1:0]      w_phase;
    logic [PHASE_WIDTH:0]        w_raw;
    logic                        w_wrap;
    logic [PHASE_WIDTH-1:0]      w_delta_src;
    logic [AXIS_TDATA_WIDTH-1:0] w_delta;

    logic                        r_first;
    logic [PHASE_WIDTH-1:0]      r_phase_prev;
    logic                        r_s1_valid;
    logic                        r_s1_first;
    logic                        r_s1_wrap;
    logic [AXIS_TDATA_WIDTH-1:0] r_s1_delta;
    logic [WRAP_COUNT_WIDTH-1:0] r_wrap_count;

    assign w_phase = S_AXIS_tdata[PHASE_WIDTH-1:0];

    // Bits above the phase field carry no information for this stage.
    if (AXIS_TDATA_WIDTH > PHASE_WIDTH) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^S_AXIS_tdata[AXIS_TDATA_WIDTH-1:PHASE_WIDTH];
    end

    // One extra bit keeps the true difference; a wrap is when it does not fit PHASE_WIDTH bits.
    assign w_raw       = {w_phase[PHASE_WIDTH-1], w_phase}
                       - {r_phase_prev[PHASE_WIDTH-1], r_phase_prev};
    assign w_wrap      = w_raw[PHASE_WIDTH] ^ w_raw[PHASE_WIDTH-1];
    assign w_delta_src = r_first ? w_phase : w_raw[PHASE_WIDTH-1:0];
    assign w_delta     = AXIS_TDATA_WIDTH'($signed(w_delta_src));

    // Stage 1: capture delta and flags, track the last accepted phase.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            r_first      <= 1'b1;
            r_phase_prev <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_first   <= 1'b0;
            r_s1_wrap    <= 1'b0;
            r_s1_delta   <= '0;
        end else if (PU_clear) begin
            r_first      <= 1'b1;
            r_phase_prev <= '0;
            r_s1_valid   <= 1'b0;
        end else begin
            r_s1_valid <= S_AXIS_tvalid;
            if (S_AXIS_tvalid) begin
                r_first      <= 1'b0;
                r_phase_prev <= w_phase;
                r_s1_first   <= r_first;
                r_s1_wrap    <= w_wrap & ~r_first;
                r_s1_delta   <= w_delta;
            end
        end
    end

    // Wrap counter advances alongside the stage-2 output it belongs to, sticking at all-ones.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            r_wrap_count <= '0;
        end else if (PU_clear) begin
            r_wrap_count <= '0;
        end else if (r_s1_valid && r_s1_wrap && (r_wrap_count != '1)) begin
            r_wrap_count <= r_wrap_count + c_count_one;
        end
    end

    pu_accumulator #(
        .AXIS_TDATA_WIDTH (AXIS_TDATA_WIDTH)
    ) u_accumulator (
        .clk     (SYS_aclk),
        .rst_n   (SYS_aresetn),
        .i_clear (PU_clear),
        .i_valid (r_s1_valid),
        .i_first (r_s1_first),
        .i_delta (r_s1_delta),
        .o_acc   (M_AXIS_tdata),
        .o_valid (M_AXIS_tvalid)
    );

    assign PU_wrap_count = r_wrap_count;

endmodule : phase_unwrapper
`default_nettype wire

// File: tb/tb_phase_unwrapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_unwrapper
//  Description : Directed self-checking bench for phase_unwrapper. A 32-bit
//                instance carries the main scenarios; a 20-bit instance on
//                the same stimulus covers accumulator overflow behaviour
//                (PHASE_UNWRAPPER_SAT_EN selects the expected rail value).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_unwrapper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pu_clear;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic [15:0] wrap_cnt;
    logic [19:0] m20_tdata;
    logic        m20_tvalid;
    logic [15:0] wrap20_cnt;

    int     n_vectors     = 0;
    int     n_miscompares = 0;
    int     cyc           = 0;
    longint out_q[$];
    longint out20_q[$];
    int     out_cyc_q[$];
    int     in_cyc_q[$];
    longint exp_q[$];

    phase_unwrapper #(
        .AXIS_TDATA_WIDTH (32),
        .PHASE_WIDTH      (16)
    ) u_dut (
        .SYS_aclk      (clk),
        .SYS_aresetn   (rst_n),
        .PU_clear      (pu_clear),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .PU_wrap_count (wrap_cnt)
    );

    phase_unwrapper #(
        .AXIS_TDATA_WIDTH (20),
        .PHASE_WIDTH      (16)
    ) u_dut20 (
        .SYS_aclk      (clk),
        .SYS_aresetn   (rst_n),
        .PU_clear      (pu_clear),
        .S_AXIS_tdata  (s_tdata[19:0]),
        .S_AXIS_tvalid (s_tvalid),
        .M_AXIS_tdata  (m20_tdata),
        .M_AXIS_tvalid (m20_tvalid),
        .PU_wrap_count (wrap20_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_tvalid) begin
            out_q.push_back(longint'($signed(m_tdata)));
            out_cyc_q.push_back(cyc);
        end
        if (m20_tvalid) begin
            out20_q.push_back(longint'($signed(m20_tdata)));
        end
    end

    task automatic check_vec(input string tag, input longint got, input longint exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic flush();
        out_q.delete();
        out20_q.delete();
        out_cyc_q.delete();
        in_cyc_q.delete();
        exp_q.delete();
    endtask

    // Present one sample for one edge; consecutive calls keep tvalid high.
    task automatic drive(input int ph, input bit v = 1'b1, input bit clr = 1'b0);
        s_tdata  = 32'(ph);
        s_tvalid = v;
        pu_clear = clr;
        @(posedge clk);
        #1;
        if (v && !clr) in_cyc_q.push_back(cyc);
        s_tvalid = 1'b0;
        pu_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        drive(0, 1'b0, 1'b1);
        flush();
    endtask

    task automatic compare_outputs(input string tag);
        idle(3);
        check_vec({tag, "_count"}, longint'(out_q.size()), longint'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            check_vec($sformatf("%s_out%0d", tag, i), out_q[i], exp_q[i]);
        end
        if (in_cyc_q.size() == out_cyc_q.size()) begin
            for (int i = 0; i < out_cyc_q.size(); i++) begin
                check_vec($sformatf("%s_lat%0d", tag, i),
                          longint'(out_cyc_q[i] - in_cyc_q[i]), 64'sd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic signed [15:0] p;

        rst_n    = 1'b0;
        pu_clear = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        idle(2);
        check_vec("rst_tvalid", longint'(m_tvalid), 0);
        check_vec("rst_tdata", longint'(m_tdata), 0);
        check_vec("rst_wrap", longint'(wrap_cnt), 0);
        rst_n = 1'b1;
        idle(1);

        // Positive wrap
        flush();
        drive(32000); drive(32700); drive(-32700); drive(-32000);
        exp_q = '{32000, 32700, 32836, 33536};
        compare_outputs("pos");
        check_vec("pos_wrap", longint'(wrap_cnt), 1);

        // Negative wrap (clear first so the first sample reloads)
        pulse_clear();
        drive(-32000); drive(-32700); drive(32700);
        exp_q = '{-32000, -32700, -32836};
        compare_outputs("neg");
        check_vec("neg_wrap", longint'(wrap_cnt), 1);

        // Clear with a sample in flight and another presented on the clear edge
        flush();
        drive(7);
        drive(999, 1'b1, 1'b1);
        check_vec("clr_tvalid", longint'(m_tvalid), 0);
        check_vec("clr_tdata", longint'(m_tdata), 0);
        check_vec("clr_wrap", longint'(wrap_cnt), 0);
        in_cyc_q.delete();
        drive(50);
        exp_q = '{50};
        compare_outputs("clr");
        check_vec("clr_wrap_after", longint'(wrap_cnt), 0);
        check_vec("clr_hold", longint'($signed(m_tdata)), 50);

        // Gap between samples
        pulse_clear();
        drive(100);
        idle(5);
        drive(300);
        exp_q = '{100, 300};
        compare_outputs("gap");
        check_vec("gap_wrap", longint'(wrap_cnt), 0);

        // Boundary: difference of exactly -2^15 is not a wrap
        pulse_clear();
        drive(0); drive(-32768);
        exp_q = '{0, -32768};
        compare_outputs("bnd");
        check_vec("bnd_wrap", longint'(wrap_cnt), 0);

        // Accumulator overflow on the 20-bit instance
        pulse_clear();
        for (int i = 0; i <= 18; i++) begin
            p = 16'(i * 30000);
            drive(int'(p));
        end
        drive(14712);
        idle(3);
        check_vec("sat_count", longint'(out_q.size()), 20);
        check_vec("sat20_count", longint'(out20_q.size()), 20);
        if (out_q.size() == 20) begin
            check_vec("sat_w32_s18", out_q[18], 540000);
            check_vec("sat_w32_s19", out_q[19], 539000);
        end
        if (out20_q.size() == 20) begin
`ifdef PHASE_UNWRAPPER_SAT_EN
            check_vec("sat_w20_s18", out20_q[18], 524287);
            check_vec("sat_w20_s19", out20_q[19], 523287);
`else
            check_vec("sat_w20_s18", out20_q[18], -508576);
            check_vec("sat_w20_s19", out20_q[19], -509576);
`endif
        end
        check_vec("sat_wrap32", longint'(wrap_cnt), 8);
        check_vec("sat_wrap20", longint'(wrap20_cnt), 8);

        // Reset asserted between edges while tvalid is high
        pulse_clear();
        drive(32000); drive(32700); drive(-32700);
        s_tdata  = 32'(-32000);
        s_tvalid = 1'b1;
        @(posedge clk);
        #3;
        check_vec("mrst_pre_tdata", longint'($signed(m_tdata)), 32836);
        check_vec("mrst_pre_wrap", longint'(wrap_cnt), 1);
        rst_n = 1'b0;
        #1;
        check_vec("mrst_tvalid", longint'(m_tvalid), 0);
        check_vec("mrst_tdata", longint'(m_tdata), 0);
        check_vec("mrst_wrap", longint'(wrap_cnt), 0);
        s_tvalid = 1'b0;
        #2;
        rst_n = 1'b1;
        idle(1);
        flush();
        drive(-5);
        exp_q = '{-5};
        compare_outputs("mrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_phase_unwrapper
`default_nettype wire
